// File: rtl/alu_op_sequencer_if.sv
// Request/response channel bundle between decode, the ALU op sequencer and
// writeback/PC-select. The sequencer connects through the slave modport.
interface alu_op_sequencer_if;
  // request channel
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [2:0]  req_funct3;
  logic        req_funct7b5;
  logic        req_opb5;
  logic [31:0] req_a;
  logic [31:0] req_b;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_taken;
  logic        rsp_illegal;

  modport slave (
    input  req_valid, req_aluop, req_funct3, req_funct7b5, req_opb5, req_a, req_b,
    output req_ready,
    output rsp_valid, rsp_result, rsp_flags, rsp_taken, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_aluop, req_funct3, req_funct7b5, req_opb5, req_a, req_b,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_flags, rsp_taken, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue-side controller for the 32-bit ALU: decodes ALUOp/funct into
// alu_control, holds operands for EXEC_CYCLES, captures result/flags,
// resolves branch-taken and returns it all on a valid/ready response.
// Optional feature macro: ALU_SEQ_BYPASS_EN (accept a new op in the same
// cycle the pending response is retired).
module alu_op_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic [2:0]          alu_control,
  input  logic [31:0]         alu_result,
  input  logic                alu_z,
  input  logic                alu_n,
  input  logic                alu_v,
  input  logic                alu_c
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CTRL_W-1:0] CTRL_ADD = 3'b000;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 3'b001;
  localparam logic [CTRL_W-1:0] CTRL_AND = 3'b010;
  localparam logic [CTRL_W-1:0] CTRL_OR  = 3'b011;
  localparam logic [CTRL_W-1:0] CTRL_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [2:0]          f3_q, f3_d;
  logic                branch_q, branch_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
  logic                rsp_taken_q, rsp_taken_d;
  logic                rsp_illegal_q, rsp_illegal_d;

  logic                req_ready_c;
  logic                req_fire_c;
  logic                rsp_fire_c;
  logic [CTRL_W-1:0]   dec_ctrl_c;
  logic                dec_illegal_c;
  logic                taken_c;

  // Ready is a decode of the state register, forced low while in reset
`ifdef ALU_SEQ_BYPASS_EN
  assign req_ready_c = rst_n & ((state_q == ST_IDLE) |
                                ((state_q == ST_RESP) & bus.rsp_ready));
`else
  assign req_ready_c = rst_n & (state_q == ST_IDLE);
`endif

  assign req_fire_c = bus.req_valid & req_ready_c;
  assign rsp_fire_c = rsp_valid_q & bus.rsp_ready;

  // Map ALUOp/funct3/funct7b5/opb5 onto alu_control and flag unsupported ops
  always_comb begin
    dec_ctrl_c    = CTRL_ADD;
    dec_illegal_c = 1'b0;
    case (bus.req_aluop)
      2'b00: dec_ctrl_c = CTRL_ADD;
      2'b01: begin
        dec_ctrl_c = CTRL_SUB;
        if (bus.req_funct3 == 3'b010 || bus.req_funct3 == 3'b011) begin
          dec_illegal_c = 1'b1;
        end
      end
      2'b10: begin
        case (bus.req_funct3)
          3'b000:  dec_ctrl_c = (bus.req_opb5 & bus.req_funct7b5) ? CTRL_SUB : CTRL_ADD;
          3'b010:  dec_ctrl_c = CTRL_SLT;
          3'b110:  dec_ctrl_c = CTRL_OR;
          3'b111:  dec_ctrl_c = CTRL_AND;
          default: dec_illegal_c = 1'b1;
        endcase
      end
      default: dec_illegal_c = 1'b1;
    endcase
    if (dec_illegal_c) begin
      dec_ctrl_c = CTRL_ADD;
    end
  end

  // Branch condition from the live ALU flags, qualified by the latched op
  always_comb begin
    taken_c = 1'b0;
    case (f3_q)
      3'b000:  taken_c = alu_z;
      3'b001:  taken_c = ~alu_z;
      3'b100:  taken_c = alu_n ^ alu_v;
      3'b101:  taken_c = ~(alu_n ^ alu_v);
      3'b110:  taken_c = ~alu_c;
      3'b111:  taken_c = alu_c;
      default: taken_c = 1'b0;
    endcase
    taken_c = taken_c & branch_q;
  end

  // Next-state and register updates; accept can happen in IDLE or (bypass) RESP
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    ctrl_d        = ctrl_q;
    f3_d          = f3_q;
    branch_d      = branch_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_taken_d   = rsp_taken_q;
    rsp_illegal_d = rsp_illegal_q;

    case (state_q)
      ST_IDLE: begin
        rsp_valid_d = 1'b0;
      end
      ST_EXEC: begin
        if (cnt_q == CNT_W'(0)) begin
          rsp_result_d  = alu_result;
          rsp_flags_d   = {alu_n, alu_z, alu_c, alu_v};
          rsp_taken_d   = taken_c;
          rsp_illegal_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_fire_c) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    if (req_fire_c) begin
      alu_a_d  = bus.req_a;
      alu_b_d  = bus.req_b;
      ctrl_d   = dec_ctrl_c;
      f3_d     = bus.req_funct3;
      branch_d = (bus.req_aluop == 2'b01);
      if (dec_illegal_c) begin
        rsp_result_d  = '0;
        rsp_flags_d   = '0;
        rsp_taken_d   = 1'b0;
        rsp_illegal_d = 1'b1;
        rsp_valid_d   = 1'b1;
        state_d       = ST_RESP;
      end else begin
        cnt_d       = CNT_W'(EXEC_CYCLES - 1);
        rsp_valid_d = 1'b0;
        state_d     = ST_EXEC;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      ctrl_q        <= '0;
      f3_q          <= '0;
      branch_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      ctrl_q        <= ctrl_d;
      f3_q          <= f3_d;
      branch_q      <= branch_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_taken_q   <= rsp_taken_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_control     = ctrl_q;
  assign bus.req_ready   = req_ready_c;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_flags   = rsp_flags_q;
  assign bus.rsp_taken   = rsp_taken_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table plus hand-written
// sequences for stall, back-to-back issue and reset mid-EXEC.
module tb_alu_op_sequencer;

  localparam int unsigned EXEC = 3;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;
  logic        alu_z, alu_n, alu_v, alu_c;

  alu_op_sequencer_if ifc ();

  alu_op_sequencer #(.EXEC_CYCLES(EXEC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc.slave),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_z       (alu_z),
    .alu_n       (alu_n),
    .alu_v       (alu_v),
    .alu_c       (alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 32-bit ALU the sequencer drives
  logic [32:0] sum;
  always_comb begin
    sum        = '0;
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_control)
      3'b000: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[31:0];
        alu_c      = sum[32];
        alu_v      = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b001: begin
        sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = sum[31:0];
        alu_c      = sum[32];
        alu_v      = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
    alu_z = (alu_result == 32'd0);
    alu_n = alu_result[31];
  end

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7b5;
    logic        opb5;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        taken;
    logic        illegal;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        taken;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [1:0] aluop, input logic [2:0] f3,
                              input logic f7b5, input logic opb5,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] ctrl, input logic [31:0] res,
                              input logic [3:0] flags, input logic taken,
                              input logic illegal);
    vec_t v;
    v.aluop = aluop; v.f3 = f3; v.f7b5 = f7b5; v.opb5 = opb5;
    v.a = a; v.b = b; v.ctrl = ctrl; v.res = res; v.flags = flags;
    v.taken = taken; v.illegal = illegal;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ifc.req_aluop    = v.aluop;
    ifc.req_funct3   = v.f3;
    ifc.req_funct7b5 = v.f7b5;
    ifc.req_opb5     = v.opb5;
    ifc.req_a        = v.a;
    ifc.req_b        = v.b;
  endtask

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.res = v.res; e.flags = v.flags; e.taken = v.taken; e.illegal = v.illegal;
    return e;
  endfunction

  task automatic cmp_outputs(input exp_t e, input string tag);
    check({tag, "_valid"},   32'(ifc.rsp_valid),   32'd1);
    check({tag, "_result"},  ifc.rsp_result,       e.res);
    check({tag, "_flags"},   32'(ifc.rsp_flags),   32'(e.flags));
    check({tag, "_taken"},   32'(ifc.rsp_taken),   32'(e.taken));
    check({tag, "_illegal"}, 32'(ifc.rsp_illegal), 32'(e.illegal));
  endtask

  // Retire the front scoreboard entry against the presented response
  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: response with empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      cmp_outputs(e, tag);
    end
  endtask

  // Count edges (accept edge = 1) until rsp_valid, checking held ALU inputs
  task automatic wait_rsp(input logic chk_in, input vec_t v, input string tag, output int edges);
    edges = 1;
    while (!ifc.rsp_valid && edges < 40) begin
      if (chk_in) begin
        check({tag, "_alu_a"},   alu_a,              v.a);
        check({tag, "_alu_b"},   alu_b,              v.b);
        check({tag, "_alu_ctl"}, 32'(alu_control),   32'(v.ctrl));
      end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_op(input vec_t v, input int stall, input string tag);
    int n;
    int edges;
    n = 0;
    while (!ifc.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_req_ready"}, 32'(ifc.req_ready), 32'd1);
    drive(v);
    ifc.req_valid = 1'b1;
    @(posedge clk);
    sb.push_back(to_exp(v));
    #1;
    ifc.req_valid = 1'b0;
    wait_rsp(!v.illegal, v, tag, edges);
    check({tag, "_latency"}, 32'(edges), v.illegal ? 32'd1 : 32'(EXEC + 1));
    for (int s = 0; s < stall; s++) begin
      if (sb.size() != 0) cmp_outputs(sb[0], {tag, "_hold"});
      check({tag, "_hold_req_ready"}, 32'(ifc.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    ifc.rsp_ready = 1'b1;
    pop_compare(tag);
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 32'(ifc.rsp_valid), 32'd0);
    if (!v.illegal) begin
      check({tag, "_keep_a"}, alu_a, v.a);
      check({tag, "_keep_b"}, alu_b, v.b);
    end
  endtask

  vec_t vecs[16];
  vec_t va, vb;
  int   edges;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(2'b00, 3'b000, 1'b0, 1'b0, 32'd5,        32'd7,        3'b000, 32'd12,       4'b0000, 1'b0, 1'b0);
    vecs[1]  = mk(2'b01, 3'b000, 1'b0, 1'b0, 32'h1234,     32'h1234,     3'b001, 32'd0,        4'b0110, 1'b1, 1'b0);
    vecs[2]  = mk(2'b01, 3'b110, 1'b0, 1'b0, 32'd3,        32'd5,        3'b001, 32'hFFFFFFFE, 4'b1000, 1'b1, 1'b0);
    vecs[3]  = mk(2'b01, 3'b101, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        3'b001, 32'hFFFFFFFE, 4'b1010, 1'b0, 1'b0);
    vecs[4]  = mk(2'b10, 3'b001, 1'b0, 1'b1, 32'd9,        32'd9,        3'b000, 32'd0,        4'b0000, 1'b0, 1'b1);
    vecs[5]  = mk(2'b10, 3'b000, 1'b1, 1'b1, 32'd3,        32'd5,        3'b001, 32'hFFFFFFFE, 4'b1000, 1'b0, 1'b0);
    vecs[6]  = mk(2'b10, 3'b010, 1'b0, 1'b1, 32'd3,        32'd5,        3'b101, 32'd1,        4'b0000, 1'b0, 1'b0);
    vecs[7]  = mk(2'b10, 3'b000, 1'b1, 1'b0, 32'd10,       32'd20,       3'b000, 32'd30,       4'b0000, 1'b0, 1'b0);
    vecs[8]  = mk(2'b10, 3'b110, 1'b0, 1'b1, 32'hF0,       32'h0F,       3'b011, 32'hFF,       4'b0000, 1'b0, 1'b0);
    vecs[9]  = mk(2'b10, 3'b111, 1'b0, 1'b1, 32'hFF00FF00, 32'h0FF00FF0, 3'b010, 32'h0F000F00, 4'b0000, 1'b0, 1'b0);
    vecs[10] = mk(2'b11, 3'b000, 1'b0, 1'b0, 32'd1,        32'd2,        3'b000, 32'd0,        4'b0000, 1'b0, 1'b1);
    vecs[11] = mk(2'b01, 3'b010, 1'b0, 1'b0, 32'd1,        32'd2,        3'b000, 32'd0,        4'b0000, 1'b0, 1'b1);
    vecs[12] = mk(2'b01, 3'b001, 1'b0, 1'b0, 32'd1,        32'd2,        3'b001, 32'hFFFFFFFF, 4'b1000, 1'b1, 1'b0);
    vecs[13] = mk(2'b01, 3'b100, 1'b0, 1'b0, 32'h80000000, 32'd1,        3'b001, 32'h7FFFFFFF, 4'b0011, 1'b1, 1'b0);
    vecs[14] = mk(2'b01, 3'b111, 1'b0, 1'b0, 32'd5,        32'd3,        3'b001, 32'd2,        4'b0010, 1'b1, 1'b0);
    vecs[15] = mk(2'b00, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,        4'b0110, 1'b0, 1'b0);

    rst_n         = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b0;
    drive(vecs[0]);

    // Reset values
    #23;
    check("rst_req_ready", 32'(ifc.req_ready),  32'd0);
    check("rst_rsp_valid", 32'(ifc.rsp_valid),  32'd0);
    check("rst_alu_a",     alu_a,               32'd0);
    check("rst_alu_ctl",   32'(alu_control),    32'd0);
    check("rst_rsp_res",   ifc.rsp_result,      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", 32'(ifc.req_ready),  32'd1);
    check("rel_rsp_valid", 32'(ifc.rsp_valid),  32'd0);
    @(posedge clk); #1;

    // Vector table, first op with a 5-cycle response stall
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i], (i == 0) ? 5 : 0, $sformatf("vec%0d", i));
    end

    // Response retire overlapped with the next request
    va = vecs[5];
    vb = vecs[6];
    drive(va);
    ifc.req_valid = 1'b1;
    @(posedge clk);
    sb.push_back(to_exp(va));
    #1;
    ifc.req_valid = 1'b0;
    wait_rsp(1'b1, va, "b2b_a", edges);
    check("b2b_a_latency", 32'(edges), 32'(EXEC + 1));
    drive(vb);
    ifc.req_valid = 1'b1;
    ifc.rsp_ready = 1'b1;
    #1;
`ifdef ALU_SEQ_BYPASS_EN
    check("b2b_resp_ready", 32'(ifc.req_ready), 32'd1);
`else
    check("b2b_resp_ready", 32'(ifc.req_ready), 32'd0);
`endif
    pop_compare("b2b_a");
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
`ifndef ALU_SEQ_BYPASS_EN
    check("b2b_idle_ctl",   32'(alu_control),   32'(va.ctrl));
    check("b2b_idle_ready", 32'(ifc.req_ready), 32'd1);
    @(posedge clk); #1;
`endif
    sb.push_back(to_exp(vb));
    ifc.req_valid = 1'b0;
    check("b2b_b_started", 32'(ifc.rsp_valid), 32'd0);
    wait_rsp(1'b1, vb, "b2b_b", edges);
    check("b2b_b_latency", 32'(edges), 32'(EXEC + 1));
    ifc.rsp_ready = 1'b1;
    pop_compare("b2b_b");
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;

    // Reset asserted mid-EXEC drops the op
    drive(vecs[0]);
    ifc.req_valid = 1'b1;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a",     alu_a,              32'd0);
    check("mid_rst_alu_ctl",   32'(alu_control),   32'd0);
    check("mid_rst_req_ready", 32'(ifc.req_ready), 32'd0);
    check("mid_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(ifc.req_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("post_rst_no_rsp", 32'(ifc.rsp_valid), 32'd0);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
